// File: rtl/md_unit.sv
// ============================================================================
// Module      : md_unit
// Description : Multi-cycle multiply/divide unit holding the architectural
//               HI/LO registers. Runs MULT/MULTU/DIV/DIVU for a fixed number
//               of cycles, services MTHI/MTLO writes, and exposes a
//               registered busy flag for decode-stage stalling.
//               Optional macro MD_CANCEL_EN adds a cancel input that aborts
//               an in-flight operation without committing to HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_unit #(
   parameter int MUL_LAT = 5,   // busy cycles for MULT/MULTU (>= 1)
   parameter int DIV_LAT = 10   // busy cycles for DIV/DIVU (>= 1)
) (
   input  logic        clk,
   input  logic        rst,     // asynchronous, active-low
   input  logic        start,
   input  logic [1:0]  MDOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        HIWr,
   input  logic        LOWr,
   input  logic [31:0] WD,
`ifdef MD_CANCEL_EN
   input  logic        cancel,
`endif
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_DIV   = 2'b10;

   logic [0:0]       state;
   logic [0:0]       state_nx;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       op_q;
   logic [31:0]      a_q;
   logic [31:0]      b_q;

   logic             cancel_req;
   logic             launch;
   logic             commit;
   logic             hi_we;
   logic             lo_we;
   logic [31:0]      hi_nx;
   logic [31:0]      lo_nx;

`ifdef MD_CANCEL_EN
   assign cancel_req = cancel;
`else
   assign cancel_req = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Arithmetic on the latched operands. The result is only consumed on the
   // commit edge, so the operands stay stable for the whole run.
   // ------------------------------------------------------------------------
   logic        mul_signed;
   logic [63:0] mul_a;
   logic [63:0] mul_b;
   logic [63:0] prod;

   logic        is_div;
   logic        div_signed;
   logic        div_zero;
   logic [31:0] dvd_mag;
   logic [31:0] dvs_mag;
   logic [31:0] dvs_safe;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] quot;
   logic [31:0] rem;

   assign mul_signed = (op_q == OP_MULT);
   assign mul_a      = {{32{a_q[31] & mul_signed}}, a_q};
   assign mul_b      = {{32{b_q[31] & mul_signed}}, b_q};
   assign prod       = mul_a * mul_b;

   // Signed divide is done on magnitudes; this keeps 0x80000000 / -1 well
   // defined (quotient wraps to 0x80000000, remainder 0).
   assign is_div     = op_q[1];
   assign div_signed = (op_q == OP_DIV);
   assign div_zero   = (b_q == 32'd0);
   assign dvd_mag    = (div_signed && a_q[31]) ? (~a_q + 32'd1) : a_q;
   assign dvs_mag    = (div_signed && b_q[31]) ? (~b_q + 32'd1) : b_q;
   assign dvs_safe   = div_zero ? 32'd1 : dvs_mag;
   assign q_mag      = dvd_mag / dvs_safe;
   assign r_mag      = dvd_mag % dvs_safe;
   assign quot       = (div_signed && (a_q[31] ^ b_q[31])) ? (~q_mag + 32'd1) : q_mag;
   assign rem        = (div_signed && a_q[31]) ? (~r_mag + 32'd1) : r_mag;

   // State register: IDLE/RUN, cleared asynchronously on reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic: launch on start, finish on last count or cancel.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (start && !cancel_req) begin
               state_nx = S_RUN;
            end
         end
         S_RUN: begin
            if (cancel_req || (cnt == CNT_W'(1))) begin
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Output/control decode: busy, launch/commit strobes and HI/LO write enables.
   always_comb begin
      busy   = (state == S_RUN);
      launch = (state == S_IDLE) && start && !cancel_req;
      commit = (state == S_RUN) && !cancel_req && (cnt == CNT_W'(1));
      hi_we  = 1'b0;
      lo_we  = 1'b0;
      hi_nx  = WD;
      lo_nx  = WD;
      if (commit) begin
         if (!is_div) begin
            hi_we = 1'b1;
            lo_we = 1'b1;
            hi_nx = prod[63:32];
            lo_nx = prod[31:0];
         end else if (!div_zero) begin
            hi_we = 1'b1;
            lo_we = 1'b1;
            hi_nx = rem;
            lo_nx = quot;
         end
      end else if ((state == S_IDLE) && !launch) begin
         // MTHI/MTLO only land when idle and not displaced by a start.
         hi_we = HIWr;
         lo_we = LOWr;
      end
   end

   // Operand latch and latency counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= '0;
         op_q <= 2'b00;
         a_q  <= 32'd0;
         b_q  <= 32'd0;
      end else if (launch) begin
         cnt  <= MDOp[1] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
         op_q <= MDOp;
         a_q  <= A;
         b_q  <= B;
      end else if (state == S_RUN) begin
         if (cancel_req) begin
            cnt <= '0;
         end else begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

   // Architectural HI/LO registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         HI <= 32'd0;
         LO <= 32'd0;
      end else begin
         if (hi_we) begin
            HI <= hi_nx;
         end
         if (lo_we) begin
            LO <= lo_nx;
         end
      end
   end

endmodule

`default_nettype wire
